// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file (regfile_mp).
// Holds the default geometry, the default register address type and the
// architectural zero-register address.
package rf_pkg;

    localparam int RF_DATAWIDTH = 32;
    localparam int RF_NUM_REGS  = 32;
    localparam int RF_ADDRW     = $clog2(RF_NUM_REGS);

    typedef logic [RF_ADDRW-1:0] rf_addr_t;

    // Register 0 is hardwired to zero when ZERO_REG is enabled.
    localparam rf_addr_t ZERO_ADDR = '0;

endpackage : rf_pkg

// File: rtl/rf_wr_resolve.sv
// Combinational write-port priority resolver.
// Given one register address and all write ports, reports whether any enabled
// port targets that address and which data wins (highest port index wins).
module rf_wr_resolve
    import rf_pkg::*;
#(
    parameter int DATAWIDTH = RF_DATAWIDTH,
    parameter int ADDRW     = RF_ADDRW,
    parameter int NUM_WR    = 2
) (
    input  logic [ADDRW-1:0]            addr_i,
    input  logic [NUM_WR-1:0]           wr_en_i,
    input  logic [NUM_WR*ADDRW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATAWIDTH-1:0] wr_data_i,
    output logic                        hit_o,
    output logic [DATAWIDTH-1:0]        data_o
);

    // Scan ports in ascending order so a later (higher-priority) match overrides.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // no-hit path would leave the value unassigned and infer a latch.
        hit_o  = 1'b0;
        data_o = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDRW +: ADDRW] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[w*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule : rf_wr_resolve

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD registered read ports,
// NUM_WR write ports (higher index wins), same-cycle write-to-read forwarding,
// optional hardwired-zero register 0 and out-of-range address masking.
// Optional busy scoreboard for the issue stage, enabled by defining
// REGFILE_SCOREBOARD_EN; without it rd_busy is tied to 0.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATAWIDTH = RF_DATAWIDTH,
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int ADDRW     = $clog2(NUM_REGS),
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_RD*ADDRW-1:0]     rd_addr,
    output logic [NUM_RD*DATAWIDTH-1:0] rd_data,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*ADDRW-1:0]     wr_addr,
    input  logic [NUM_WR*DATAWIDTH-1:0] wr_data,
    input  logic                        alloc_en,
    input  logic [ADDRW-1:0]            alloc_addr,
    output logic [NUM_RD-1:0]           rd_busy
);

    // One extra bit so NUM_REGS itself is representable when it is a power of 2.
    localparam logic [ADDRW:0] REG_LIMIT = (ADDRW+1)'(NUM_REGS);

    function automatic logic addr_in_range(input logic [ADDRW-1:0] a);
        return ({1'b0, a} < REG_LIMIT);
    endfunction

    function automatic logic addr_writable(input logic [ADDRW-1:0] a);
        return addr_in_range(a) && !((ZERO_REG != 0) && (a == ADDRW'(ZERO_ADDR)));
    endfunction

    // ------------------------------------------------------------------
    // Write qualification: drop writes to nonexistent registers and to the
    // hardwired zero register, so neither the array nor forwarding sees them.
    // ------------------------------------------------------------------
    logic [NUM_WR-1:0] wr_ok;

    // Per-port write enable after address filtering.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wr_en[w] && addr_writable(wr_addr[w*ADDRW +: ADDRW]);
        end
    end

    // ------------------------------------------------------------------
    // Register array: one resolver per register picks the winning write.
    // ------------------------------------------------------------------
    logic [DATAWIDTH-1:0] regs_q [NUM_REGS];
    logic [DATAWIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  reg_hit;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [DATAWIDTH-1:0] win_data;

        rf_wr_resolve #(
            .DATAWIDTH (DATAWIDTH),
            .ADDRW     (ADDRW),
            .NUM_WR    (NUM_WR)
        ) u_res (
            .addr_i    (ADDRW'(r)),
            .wr_en_i   (wr_ok),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (reg_hit[r]),
            .data_o    (win_data)
        );

        assign regs_d[r] = reg_hit[r] ? win_data : regs_q[r];
    end

    // Array state update; the whole array clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is deliberately built from resettable flops,
            // not a RAM macro, because every register must read 0 after reset.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: forward the winning same-cycle write, else the array.
    // ------------------------------------------------------------------
    logic [DATAWIDTH-1:0] rd_word_d [NUM_RD];
    logic [DATAWIDTH-1:0] rd_word_q [NUM_RD];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDRW-1:0]     addr;
        logic                 fwd_hit;
        logic [DATAWIDTH-1:0] fwd_data;

        assign addr = rd_addr[p*ADDRW +: ADDRW];

        rf_wr_resolve #(
            .DATAWIDTH (DATAWIDTH),
            .ADDRW     (ADDRW),
            .NUM_WR    (NUM_WR)
        ) u_fwd (
            .addr_i    (addr),
            .wr_en_i   (wr_ok),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (fwd_hit),
            .data_o    (fwd_data)
        );

        assign rd_word_d[p] = !addr_in_range(addr) ? '0 :
                              fwd_hit              ? fwd_data : regs_q[addr];

        assign rd_data[p*DATAWIDTH +: DATAWIDTH] = rd_word_q[p];
    end

    // Registered read data (1-cycle read latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_word_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_word_q[p] <= rd_word_d[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_RD-1:0]   rd_busy_d;
    logic [NUM_RD-1:0]   rd_busy_q;
    logic                alloc_ok;

    assign alloc_ok = alloc_en && addr_writable(alloc_addr);

    // Next busy vector: allocation (new producer) beats a completing write.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (alloc_ok && (alloc_addr == ADDRW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (reg_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
        logic [ADDRW-1:0] addr;
        assign addr         = rd_addr[p*ADDRW +: ADDRW];
        assign rd_busy_d[p] = addr_in_range(addr) && busy_d[addr];
    end

    // Busy vector and per-port registered busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_busy = rd_busy_q;
`else
    // Scoreboard absent: allocation inputs are accepted but have no effect.
    logic unused_alloc;
    assign unused_alloc = ^{alloc_en, alloc_addr};
    assign rd_busy      = '0;
`endif

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp.
// dut_a: default geometry (32 regs, 2R2W, hardwired zero register).
// dut_b: 24 regs, 4R1W, register 0 ordinary (non-power-of-2 address space).
// Expected values come from an array-based model that applies each cycle's
// writes in port order, then answers reads from the updated array.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- dut_a signals ----------------
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic [1:0]  a_rd_busy;

    // ---------------- dut_b signals ----------------
    logic [19:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [0:0]   b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic         b_alloc_en;
    logic [4:0]   b_alloc_addr;
    logic [3:0]   b_rd_busy;

    regfile_mp dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data),
        .alloc_en   (a_alloc_en),
        .alloc_addr (a_alloc_addr),
        .rd_busy    (a_rd_busy)
    );

    regfile_mp #(
        .NUM_REGS (24),
        .NUM_RD   (4),
        .NUM_WR   (1),
        .ZERO_REG (0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .alloc_en   (b_alloc_en),
        .alloc_addr (b_alloc_addr),
        .rd_busy    (b_rd_busy)
    );

`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    // ---------------- reference model ----------------
    logic [31:0] ma [32];
    bit          ma_busy [32];
    logic [31:0] mb [24];
    bit          mb_busy [24];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            ma_busy[i] = 1'b0;
        end
        for (int i = 0; i < 24; i++) begin
            mb[i] = '0;
            mb_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_alloc_en = 1'b0; a_alloc_addr = '0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_alloc_en = 1'b0; b_alloc_addr = '0;
    endtask

    // Apply the current inputs to the model, clock once, compare every read port.
    task automatic step(input string tag);
        logic [31:0] na [32];
        bit          nba [32];
        logic [31:0] nb [24];
        bit          nbb [24];
        logic [31:0] ea [2];
        logic [31:0] eb [4];
        bit          eab [2];
        bit          ebb [4];
        int          ad;

        na = ma; nba = ma_busy; nb = mb; nbb = mb_busy;

        // dut_a: ascending port order lets port 1 overwrite port 0; reg 0 is fixed at 0.
        for (int w = 0; w < 2; w++) begin
            ad = int'(a_wr_addr[w*5 +: 5]);
            if (a_wr_en[w] && ad != 0) begin
                na[ad]  = a_wr_data[w*32 +: 32];
                nba[ad] = 1'b0;
            end
        end
        if (a_alloc_en && a_alloc_addr != 0) nba[a_alloc_addr] = 1'b1;

        // dut_b: only addresses below 24 exist.
        ad = int'(b_wr_addr);
        if (b_wr_en[0] && ad < 24) begin
            nb[ad]  = b_wr_data;
            nbb[ad] = 1'b0;
        end
        if (b_alloc_en && int'(b_alloc_addr) < 24) nbb[b_alloc_addr] = 1'b1;

        for (int p = 0; p < 2; p++) begin
            ad = int'(a_rd_addr[p*5 +: 5]);
            ea[p]  = na[ad];
            eab[p] = SB && nba[ad];
        end
        for (int p = 0; p < 4; p++) begin
            ad = int'(b_rd_addr[p*5 +: 5]);
            eb[p]  = (ad < 24) ? nb[ad] : 32'h0;
            ebb[p] = SB && (ad < 24) && nbb[ad];
        end

        @(posedge clk);
        #1;
        ma = na; ma_busy = nba; mb = nb; mb_busy = nbb;

        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s a.data%0d", tag, p), a_rd_data[p*32 +: 32], ea[p]);
            check($sformatf("%s a.busy%0d", tag, p), {31'b0, a_rd_busy[p]}, {31'b0, eab[p]});
        end
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s b.data%0d", tag, p), b_rd_data[p*32 +: 32], eb[p]);
            check($sformatf("%s b.busy%0d", tag, p), {31'b0, b_rd_busy[p]}, {31'b0, ebb[p]});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();

        // ---- power-on reset state ----
        #3;
        check("por a.data", a_rd_data[31:0] | a_rd_data[63:32], 32'h0);
        check("por b.data", b_rd_data[31:0] | b_rd_data[63:32] | b_rd_data[95:64] | b_rd_data[127:96], 32'h0);
        check("por busy", {26'b0, a_rd_busy, b_rd_busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- same-cycle forwarding ----
        a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEADBEEF;
        a_rd_addr[4:0] = 5'd5;
        step("fwd");
        check("fwd const", a_rd_data[31:0], 32'hDEADBEEF);
        idle();
        a_rd_addr[9:5] = 5'd5;
        step("fwd later");
        check("fwd later const", a_rd_data[63:32], 32'hDEADBEEF);

        // ---- write conflict: port 1 wins ----
        a_wr_en = 2'b11;
        a_wr_addr = {5'd7, 5'd7};
        a_wr_data = {32'h22, 32'h11};
        a_rd_addr = {5'd5, 5'd7};
        step("conflict");
        check("conflict fwd const", a_rd_data[31:0], 32'h22);
        idle();
        a_rd_addr = {5'd7, 5'd7};
        step("conflict later");
        check("conflict reg const", a_rd_data[63:32], 32'h22);

        // ---- zero register: dut_a hardwired, dut_b ordinary ----
        a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd0; a_wr_data[63:32] = 32'hFFFFFFFF;
        a_rd_addr = '0;
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'hFFFFFFFF;
        b_rd_addr = '0;
        step("zero");
        check("zero a fwd const", a_rd_data[31:0], 32'h0);
        check("zero b fwd const", b_rd_data[31:0], 32'hFFFFFFFF);
        idle();
        step("zero later");
        check("zero a later const", a_rd_data[63:32], 32'h0);
        check("zero b later const", b_rd_data[127:96], 32'hFFFFFFFF);

        // ---- scoreboard ----
        a_alloc_en = 1'b1; a_alloc_addr = 5'd3; a_rd_addr = {5'd0, 5'd3};
        step("sb alloc");
        check("sb alloc const", {31'b0, a_rd_busy[0]}, {31'b0, SB});
        a_alloc_en = 1'b0;
        a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'h33;
        step("sb write");
        check("sb write const", {31'b0, a_rd_busy[0]}, 32'h0);
        a_alloc_en = 1'b1;
        step("sb both");
        check("sb both const", {31'b0, a_rd_busy[0]}, {31'b0, SB});
        a_alloc_en = 1'b0; a_wr_en = '0; a_alloc_addr = 5'd0;
        a_alloc_en = 1'b1;
        step("sb alloc zero");
        idle();

        // ---- out-of-range address on dut_b ----
        b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 32'h12345678;
        b_rd_addr = {5'd30, 5'd30, 5'd30, 5'd30};
        b_alloc_en = 1'b1; b_alloc_addr = 5'd30;
        step("oor");
        check("oor fwd const", b_rd_data[31:0], 32'h0);
        idle();
        b_rd_addr = {5'd30, 5'd0, 5'd23, 5'd30};
        step("oor later");
        check("oor later const", b_rd_data[31:0], 32'h0);

        // ---- mid-cycle asynchronous reset ----
        a_wr_en = 2'b11; a_wr_addr = {5'd9, 5'd8}; a_wr_data = {32'hA5A5A5A5, 32'h5A5A5A5A};
        a_rd_addr = {5'd9, 5'd8};
        step("preload");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async a.data", a_rd_data[31:0] | a_rd_data[63:32], 32'h0);
        check("async b.data", b_rd_data[31:0] | b_rd_data[127:96], 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_rd_addr = {5'(2*i+1), 5'(2*i)};
            b_rd_addr = {5'(i+16), 5'(i+8), 5'(i+4), 5'(i)};
            step("post reset");
            check("post reset const", a_rd_data[31:0] | a_rd_data[63:32], 32'h0);
        end

        // ---- random traffic ----
        for (int n = 0; n < 400; n++) begin
            a_wr_en   = 2'($urandom);
            a_wr_addr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) a_wr_addr[9:5] = a_wr_addr[4:0];
            a_wr_data = {$urandom, $urandom};
            a_rd_addr = 10'($urandom);
            if ($urandom_range(0, 2) == 0) a_rd_addr[4:0] = a_wr_addr[4:0];
            a_alloc_en   = 1'($urandom);
            a_alloc_addr = 5'($urandom);
            b_wr_en   = 1'($urandom);
            b_wr_addr = 5'($urandom);
            b_wr_data = $urandom;
            b_rd_addr = 20'($urandom);
            if ($urandom_range(0, 2) == 0) b_rd_addr[9:5] = b_wr_addr;
            b_alloc_en   = 1'($urandom);
            b_alloc_addr = 5'($urandom);
            step("rand");
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_mp
